// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes, mux selects
// and the control bundle passed from the decoder to the top level.
package control_pkg;

    localparam int unsigned ST_W = 5;

    localparam logic [ST_W-1:0] FETCH     = 5'd0;
    localparam logic [ST_W-1:0] DECODE    = 5'd1;
    localparam logic [ST_W-1:0] MEM_ADDR  = 5'd2;
    localparam logic [ST_W-1:0] MEM_READ  = 5'd3;
    localparam logic [ST_W-1:0] MEM_WB    = 5'd4;
    localparam logic [ST_W-1:0] MEM_WRITE = 5'd5;
    localparam logic [ST_W-1:0] EXEC_R    = 5'd6;
    localparam logic [ST_W-1:0] R_WB      = 5'd7;
    localparam logic [ST_W-1:0] EXEC_I    = 5'd8;
    localparam logic [ST_W-1:0] I_WB      = 5'd9;
    localparam logic [ST_W-1:0] BRANCH    = 5'd10;
    localparam logic [ST_W-1:0] JUMP      = 5'd11;
    localparam logic [ST_W-1:0] JAL       = 5'd12;
    localparam logic [ST_W-1:0] HALT      = 5'd13;
    localparam logic [ST_W-1:0] ILLEGAL   = 5'd14;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM8  = 2'b10;
    localparam logic [1:0] SRCB_IMM12 = 2'b11;

    localparam logic [1:0] DST_RD   = 2'b00;
    localparam logic [1:0] DST_RT   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational Moore decode: control bundle and next state from the current state,
// with the opcode only steering DECODE/MEM_ADDR/EXEC_R/BRANCH.
module control_decode
    import control_pkg::*;
(
    input  logic [ST_W-1:0] i_state,
    input  logic [3:0]      i_op,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    output ctrl_t           o_ctrl,
    output logic [ST_W-1:0] o_next_state
);

    // Branch resolution happens in the datapath; the flag is only carried through.
    logic w_unused_zero;
    assign w_unused_zero = i_zero;

    always_comb begin
        o_ctrl       = '0;
        o_next_state = FETCH;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_ONE;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                if (i_mem_ready) begin
                    o_ctrl.ir_write = 1'b1;
                    o_ctrl.pc_write = 1'b1;
                    o_next_state    = DECODE;
                end else begin
                    o_next_state = FETCH;
                end
            end
            DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM8;
                o_ctrl.alu_op    = ALU_ADD;
                case (i_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: o_next_state = EXEC_R;
                    OP_ADDI:                       o_next_state = EXEC_I;
                    OP_LW, OP_SW:                  o_next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE:                o_next_state = BRANCH;
                    OP_J:                          o_next_state = JUMP;
                    OP_JAL:                        o_next_state = JAL;
                    OP_HALT:                       o_next_state = HALT;
                    default:                       o_next_state = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = i_op[2:0];
                o_next_state     = R_WB;
            end
            R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = DST_RD;
                o_ctrl.mem_to_reg = M2R_ALU;
            end
            EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM8;
                o_ctrl.alu_op    = ALU_ADD;
                o_next_state     = I_WB;
            end
            I_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = DST_RT;
                o_ctrl.mem_to_reg = M2R_ALU;
            end
            MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM8;
                o_ctrl.alu_op    = ALU_ADD;
                o_next_state     = (i_op == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
                o_next_state    = i_mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = DST_RT;
                o_ctrl.mem_to_reg = M2R_MEM;
            end
            MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
                o_next_state     = i_mem_ready ? FETCH : MEM_WRITE;
            end
            BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALU_OUT;
                o_ctrl.branch_ne     = (i_op == OP_BNE);
            end
            JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            JAL: begin
                // PC already holds PC+1 from FETCH, so it is the link value.
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = DST_LINK;
                o_ctrl.mem_to_reg = M2R_PC;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
            end
            HALT: begin
                o_ctrl.halted = 1'b1;
                o_next_state  = HALT;
            end
            default: o_next_state = FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the 16-bit multicycle datapath: state register, sticky
// illegal-opcode flag and reset gating of every write enable and strobe.
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int unsigned STATE_W = 5,
    parameter int unsigned OP_W    = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    Op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNE,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               GRegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [STATE_W-1:0] current_state,
    output logic [STATE_W-1:0] next_state,
    output logic               halted,
    output logic               illegal_op
);

    logic [STATE_W-1:0] r_state;
    logic               r_illegal_op;
    logic [STATE_W-1:0] w_next_state;
    ctrl_t              w_ctrl;

    control_decode u_decode (
        .i_state      (r_state),
        .i_op         (Op),
        .i_zero       (Zero),
        .i_mem_ready  (MemReady),
        .o_ctrl       (w_ctrl),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state      <= FETCH;
            r_illegal_op <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == ILLEGAL) begin
                r_illegal_op <= 1'b1;
            end
        end
    end

    // Reset parks the FSM in FETCH, whose strobes must not reach the datapath.
    assign PCWrite     = w_ctrl.pc_write      & ~Reset;
    assign PCWriteCond = w_ctrl.pc_write_cond & ~Reset;
    assign MemRead     = w_ctrl.mem_read      & ~Reset;
    assign MemWrite    = w_ctrl.mem_write     & ~Reset;
    assign IRWrite     = w_ctrl.ir_write      & ~Reset;
    assign GRegWrite   = w_ctrl.reg_write     & ~Reset;

    assign BranchNE      = w_ctrl.branch_ne;
    assign PCSource      = w_ctrl.pc_source;
    assign IorD          = w_ctrl.iord;
    assign RegDst        = w_ctrl.reg_dst;
    assign MemToReg      = w_ctrl.mem_to_reg;
    assign ALUSrcA       = w_ctrl.alu_src_a;
    assign ALUSrcB       = w_ctrl.alu_src_b;
    assign ALUOp         = w_ctrl.alu_op;
    assign halted        = w_ctrl.halted;
    assign current_state = r_state;
    assign next_state    = w_next_state;
    assign illegal_op    = r_illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through
// its states and checks controls against hand-derived values.
module tb_multicycle_control_fsm;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       GRegWrite, ALUSrcA, halted, illegal_op;
    logic [1:0] PCSource, RegDst, MemToReg, ALUSrcB;
    logic [2:0] ALUOp;
    logic [4:0] current_state, next_state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_fsm dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .Op            (Op),
        .Zero          (Zero),
        .MemReady      (MemReady),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .BranchNE      (BranchNE),
        .PCSource      (PCSource),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .MemToReg      (MemToReg),
        .GRegWrite     (GRegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .current_state (current_state),
        .next_state    (next_state),
        .halted        (halted),
        .illegal_op    (illegal_op)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and sample on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        Reset    = 1'b1;
        Op       = 4'h0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        #1;
        check("rst_state", current_state, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_memread", MemRead, 0);
        check("rst_illegal", illegal_op, 0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        // ADD: 0,1,6,7,0
        check("fetch_state", current_state, 0);
        check("fetch_irwrite", IRWrite, 1);
        check("fetch_pcwrite", PCWrite, 1);
        check("fetch_memread", MemRead, 1);
        check("fetch_srcb", ALUSrcB, 2'b01);
        check("fetch_next", next_state, 1);
        step();
        check("add_decode", current_state, 1);
        check("decode_srcb", ALUSrcB, 2'b10);
        check("decode_regwrite", GRegWrite, 0);
        step();
        check("add_exec", current_state, 6);
        check("add_aluop", ALUOp, 3'b000);
        check("add_srca", ALUSrcA, 1);
        check("add_exec_regwrite", GRegWrite, 0);
        step();
        check("add_wb", current_state, 7);
        check("add_wb_regwrite", GRegWrite, 1);
        check("add_wb_regdst", RegDst, 2'b00);
        check("add_wb_m2r", MemToReg, 2'b00);
        step();
        check("add_done", current_state, 0);

        // LW with three wait cycles in MEM_READ
        Op = 4'h5;
        step();
        check("lw_decode", current_state, 1);
        step();
        check("lw_addr", current_state, 2);
        MemReady = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_read_state", current_state, 3);
            check("lw_read_memread", MemRead, 1);
            check("lw_read_iord", IorD, 1);
            step();
        end
        MemReady = 1'b1;
        #1;
        check("lw_read_state4", current_state, 3);
        check("lw_read_next", next_state, 4);
        step();
        check("lw_wb", current_state, 4);
        check("lw_wb_m2r", MemToReg, 2'b01);
        check("lw_wb_regdst", RegDst, 2'b01);
        check("lw_wb_regwrite", GRegWrite, 1);
        step();
        check("lw_done", current_state, 0);

        // BNE then BEQ
        Op = 4'h8;
        step();
        step();
        check("bne_state", current_state, 10);
        check("bne_cond", PCWriteCond, 1);
        check("bne_ne", BranchNE, 1);
        check("bne_pcsrc", PCSource, 2'b01);
        check("bne_aluop", ALUOp, 3'b001);
        check("bne_pcwrite", PCWrite, 0);
        step();
        check("bne_done", current_state, 0);
        Op = 4'h7;
        step();
        step();
        check("beq_state", current_state, 10);
        check("beq_ne", BranchNE, 0);
        step();

        // JAL
        Op = 4'hA;
        step();
        step();
        check("jal_state", current_state, 12);
        check("jal_regdst", RegDst, 2'b10);
        check("jal_m2r", MemToReg, 2'b10);
        check("jal_pcwrite", PCWrite, 1);
        check("jal_pcsrc", PCSource, 2'b10);
        check("jal_regwrite", GRegWrite, 1);
        step();
        check("jal_done", current_state, 0);

        // Illegal opcode, flag stays set through a following ADD
        Op = 4'hB;
        step();
        check("ill_decode", current_state, 1);
        step();
        check("ill_state", current_state, 14);
        check("ill_flag", illegal_op, 1);
        step();
        check("ill_done", current_state, 0);
        Op = 4'h0;
        repeat (4) step();
        check("ill_sticky_state", current_state, 0);
        check("ill_sticky", illegal_op, 1);

        // SW stalled, then asynchronous reset between edges
        Op = 4'h6;
        step();
        step();
        step();
        check("sw_state", current_state, 5);
        check("sw_memwrite", MemWrite, 1);
        check("sw_iord", IorD, 1);
        MemReady = 1'b0;
        step();
        check("sw_hold", current_state, 5);
        #2;
        Reset = 1'b1;
        #1;
        check("async_state", current_state, 0);
        check("async_memwrite", MemWrite, 0);
        check("async_illegal", illegal_op, 0);
        @(negedge CLK);
        Op       = 4'hF;
        MemReady = 1'b1;
        Reset    = 1'b0;
        #1;
        check("post_rst_state", current_state, 0);

        // HALT holds for 50 cycles
        step();
        step();
        check("halt_state", current_state, 13);
        check("halt_flag", halted, 1);
        Op = 4'h0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("halt_hold", current_state, 13);
        end
        check("halt_pcwrite", PCWrite, 0);
        check("halt_memread", MemRead, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style main controller that sequences the 16-bit multicycle datapath: instruction fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select.
- Exports current_state/next_state so datapath benches can probe them.
- Waits on a memory-ready handshake so slower memories can be added later without touching the datapath.

Parameters:
- STATE_W, 5, width of current_state/next_state.
- OP_W, 4, opcode width (Op = IR[15:12]).

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Op  input  4  IROut[15:12] from instruction register
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by branch condition
- BranchNE  output  1  branch condition is inverted (BNE)
- PCSource  output  2  00 ALU_Out, 01 ALU_outAfter, 10 jump target
- IorD  output  1  memory address: 0 PC, 1 ALU_outAfter
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- RegDst  output  2  write address: 00 IR[11:8], 01 IR[7:4], 10 r15 (link)
- MemToReg  output  2  writeDataIn: 00 ALU_outAfter, 01 MemOut, 10 PC
- GRegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 PC, 1 A_Input
- ALUSrcB  output  2  00 B_Input, 01 const 1, 10 sign-ext IR[7:0], 11 sign-ext IR[11:0]
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or
- current_state  output  5  registered state
- next_state  output  5  combinational next state
- halted  output  1  controller in HALT
- illegal_op  output  1  sticky: an undefined opcode was decoded

Behaviour:
- Reset, asynchronous and active-high: current_state=FETCH(0), illegal_op=0. While Reset is high, all write enables and strobes are forced to 0.
- All controls are decoded combinationally from current_state. Only IRWrite/PCWrite in FETCH are additionally gated by MemReady. Unlisted controls are 0.
- States:
  - FETCH 0: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00. IRWrite and PCWrite only when MemReady. Stay in FETCH until MemReady, then go to DECODE.
  - DECODE 1: ALUSrcA=0, ALUSrcB=10, ALUOp=add (branch target precompute). Next state by Op:
    - 0-3 -> EXEC_R
    - 4 -> EXEC_I
    - 5, 6 -> MEM_ADDR
    - 7, 8 -> BRANCH
    - 9 -> JUMP
    - A -> JAL
    - F -> HALT
    - else -> ILLEGAL
  - EXEC_R 6: ALUSrcA=1, ALUSrcB=00, ALUOp=Op[2:0]. Next R_WB.
  - R_WB 7: GRegWrite, RegDst=00, MemToReg=00. Next FETCH.
  - EXEC_I 8: ALUSrcA=1, ALUSrcB=10, ALUOp=add. Next I_WB.
  - I_WB 9: GRegWrite, RegDst=01, MemToReg=00. Next FETCH.
  - MEM_ADDR 2: ALUSrcA=1, ALUSrcB=10, add. Next MEM_READ if Op=5, else MEM_WRITE.
  - MEM_READ 3: MemRead, IorD=1. Stay until MemReady, then MEM_WB.
  - MEM_WB 4: GRegWrite, RegDst=01, MemToReg=01. Next FETCH.
  - MEM_WRITE 5: MemWrite, IorD=1. Stay until MemReady, then FETCH.
  - BRANCH 10: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond, PCSource=01, BranchNE=(Op==8). Next FETCH.
  - JUMP 11: PCWrite, PCSource=10. Next FETCH.
  - JAL 12: GRegWrite, RegDst=10, MemToReg=10, PCWrite, PCSource=10. Next FETCH. Link value is the already-incremented PC.
  - HALT 13: no enables, halted=1. Remains in HALT until Reset.
  - ILLEGAL 14: sets illegal_op (sticky until Reset). Next FETCH.
- Unused state codes 15-31 go to FETCH on the next edge; all enables are 0 while in them.
- Latency in cycles, excluding memory waits: R-type 4, I-type 4, LW 5, SW 4, branch 3, jump 3, JAL 3, illegal 3.
- MemReady low holds FETCH/MEM_READ/MEM_WRITE indefinitely with strobes held steady. MemReady is ignored in all other states.
- Reset mid-instruction aborts immediately. No partial write occurs after Reset rises.

Decomposition:
- Shared package control_pkg holds:
  - state localparams FETCH…ILLEGAL;
  - opcode constants OP_ADD…OP_HALT;
  - ALUOp, PCSource, MemToReg, ALUSrcB and RegDst encodings.
- Sub-module control_decode: purely combinational, maps current_state, Op, Zero and MemReady to the control bundle and next_state.
- Top level holds the state register and the illegal_op flag.

Test Plan:
- Reset high at t=0, release after 2 edges, MemReady=1 -> current_state=0; IRWrite=PCWrite=1 in first FETCH; DECODE next cycle.
- Op=0 (ADD), MemReady=1 -> states 0,1,6,7,0; GRegWrite=1 only in state 7 with RegDst=00; ALUOp=000 in state 6.
- Op=5 (LW), MemReady held 0 for 3 cycles in MEM_READ -> state 3 held 4 cycles, MemRead=1 and IorD=1 throughout; then state 4 with MemToReg=01, then FETCH.
- Op=8 (BNE) with Zero=0 -> BRANCH: PCWriteCond=1, BranchNE=1, PCSource=01. Op=7 -> BranchNE=0.
- Op=0xB -> DECODE then state 14; illegal_op=1 and stays 1 through the following instructions; Op=0xF -> state 13, halted=1, held for 50 cycles.
- Assert Reset asynchronously mid-MEM_WRITE (between edges) -> current_state=0 and MemWrite=0 immediately, with no clock edge needed.
